// File: rtl/arb5_pkg.sv
// Shared constants, FSM encoding and mod-5 pointer helper for the five-way round-robin arbiter.
package arb5_pkg;

    localparam int unsigned N_REQ = 5;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Advance a requester index by one, wrapping 4 -> 0.
    function automatic logic [SEL_W-1:0] inc_mod5(input logic [SEL_W-1:0] v);
        return (v >= SEL_W'(N_REQ - 1)) ? '0 : v + SEL_W'(1);
    endfunction

endpackage

// File: rtl/bus_arbiter5_if.sv
// Request/grant bundle between the five requesters and the arbiter that steers the result mux.
interface bus_arbiter5_if;
    import arb5_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             preempt;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  valid,
        input  preempt
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output valid,
        output preempt
    );

endinterface

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first set request scanning from i_ptr upward, mod 5.
module rr_pick5
    import arb5_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_found,
    output logic [N_REQ-1:0] o_onehot,
    output logic [SEL_W-1:0] o_idx
);

    logic [SEL_W-1:0] w_pos;

    always_comb begin
        o_found  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_pos    = i_ptr;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!o_found && i_req[w_pos]) begin
                o_found         = 1'b1;
                o_onehot[w_pos] = 1'b1;
                o_idx           = w_pos;
            end
            w_pos = inc_mod5(w_pos);
        end
    end

endmodule

// File: rtl/bus_arbiter5.sv
// Five-way round-robin tenure arbiter driving the result-mux select.
// Optional forced release after MAX_HOLD cycles is compiled in with ARB5_TIMEOUT_EN.
module bus_arbiter5
    import arb5_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter5_if.slave  bus
);

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [0:0]       w_nxt_state;
    logic [N_REQ-1:0] w_nxt_grant;
    logic [SEL_W-1:0] w_nxt_sel;
    logic             w_nxt_valid;
    logic [SEL_W-1:0] w_nxt_ptr;

    logic             w_owner_req;
    logic             w_owner_done;
    logic             w_others;
    logic             w_timeout;
    logic             w_release;
    logic             w_arb;
    logic [N_REQ-1:0] w_masked;
    logic             w_found;
    logic [N_REQ-1:0] w_win_onehot;
    logic [SEL_W-1:0] w_win_idx;

    // In IDLE r_grant is zero, so the mask only bites when releasing an owner.
    assign w_masked     = bus.req & ~r_grant;
    assign w_owner_req  = |(bus.req & r_grant);
    assign w_owner_done = |(bus.done & r_grant);
    assign w_others     = |w_masked;

`ifdef ARB5_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             r_preempt;
    logic             w_nxt_preempt;

    assign w_timeout   = (r_cnt == HOLD_LAST) && w_others;
    assign bus.preempt = r_preempt;
`else
    logic w_unused_max_hold;

    assign w_unused_max_hold = ^CNT_W'(MAX_HOLD);
    assign w_timeout         = 1'b0;
    assign bus.preempt       = 1'b0;
`endif

    assign w_release = !w_owner_req || w_owner_done || w_timeout;

    rr_pick5 u_pick (
        .i_req    (w_masked),
        .i_ptr    (r_ptr),
        .o_found  (w_found),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx)
    );

    // Next-state and next-output logic; arbitration reuses the same cycle as a release.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_sel   = r_sel;
        w_nxt_valid = r_valid;
        w_nxt_ptr   = r_ptr;
        w_arb       = 1'b0;
`ifdef ARB5_TIMEOUT_EN
        w_nxt_cnt     = r_cnt;
        w_nxt_preempt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: w_arb = 1'b1;
            ST_OWN: begin
                w_arb = w_release;
`ifdef ARB5_TIMEOUT_EN
                w_nxt_preempt = w_timeout && w_owner_req && !w_owner_done;
                if (!w_release && (r_cnt != HOLD_LAST)) begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
`endif
            end
            default: w_arb = 1'b1;
        endcase

        if (w_arb) begin
            if (w_found) begin
                w_nxt_state = ST_OWN;
                w_nxt_grant = w_win_onehot;
                w_nxt_sel   = w_win_idx;
                w_nxt_valid = 1'b1;
                w_nxt_ptr   = inc_mod5(w_win_idx);
`ifdef ARB5_TIMEOUT_EN
                w_nxt_cnt   = '0;
`endif
            end else begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
                w_nxt_sel   = '0;
                w_nxt_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_sel   <= w_nxt_sel;
            r_valid <= w_nxt_valid;
            r_ptr   <= w_nxt_ptr;
        end
    end

`ifdef ARB5_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_cnt     <= w_nxt_cnt;
            r_preempt <= w_nxt_preempt;
        end
    end
`endif

    assign bus.grant = r_grant;
    assign bus.sel   = r_sel;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_bus_arbiter5.sv
// Directed plus randomized bench for bus_arbiter5 against a behavioural round-robin model.
module tb_bus_arbiter5;

    localparam int MAX_HOLD = 4;
`ifdef ARB5_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    bus_arbiter5_if bus ();

    bus_arbiter5 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: owner index (-1 = none), pointer, tenure count, preempt pulse.
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_pre;

    function automatic int pick(input logic [4:0] r, input int p);
        for (int k = 0; k < 5; k++) begin
            if (r[(p + k) % 5]) return (p + k) % 5;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_step();
        logic [4:0] r;
        int  w;
        bit  oreq, odone, to;
        r     = bus.req;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_ptr = (w + 1) % 5; m_cnt = 0;
            end
        end else begin
            oreq  = bus.req[m_owner];
            odone = bus.done[m_owner];
            r[m_owner] = 1'b0;
            to    = TO_EN && (m_cnt == MAX_HOLD - 1) && (r != 5'b0);
            if (!oreq || odone || to) begin
                m_pre = to && oreq && !odone;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_ptr = (w + 1) % 5; m_cnt = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [4:0] eg;
        logic [2:0] es;
        logic       ev;
        eg = (m_owner < 0) ? 5'b0 : 5'(1 << m_owner);
        es = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        ev = (m_owner >= 0);
        n_checks++;
        assert (bus.grant === eg) else begin
            n_err++; $error("FAIL %s grant got %b exp %b", tag, bus.grant, eg);
        end
        n_checks++;
        assert (bus.sel === es) else begin
            n_err++; $error("FAIL %s sel got %0d exp %0d", tag, bus.sel, es);
        end
        n_checks++;
        assert (bus.valid === ev) else begin
            n_err++; $error("FAIL %s valid got %b exp %b", tag, bus.valid, ev);
        end
        n_checks++;
        assert (bus.preempt === m_pre) else begin
            n_err++; $error("FAIL %s preempt got %b exp %b", tag, bus.preempt, m_pre);
        end
    endtask

    task automatic expect_sel(input string tag, input logic [2:0] e);
        n_checks++;
        assert (bus.sel === e) else begin
            n_err++; $error("FAIL %s sel got %0d exp %0d", tag, bus.sel, e);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        check(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check("reset");
        rst = 1'b0;
    endtask

    initial begin
        int seq[6];
        int pre_cnt;
        seq = '{0, 1, 2, 3, 4, 0};
        rst      = 1'b1;
        bus.req  = 5'b0;
        bus.done = 5'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request: grant 2, pointer moves to 3
        bus.req = 5'b00100;
        tick("single_req");
        expect_sel("single_sel", 3'd2);
        bus.req = 5'b00001;
        bus.done = 5'b00100;
        tick("ptr_after_2");
        bus.done = 5'b0;
        bus.req = 5'b0;
        tick("to_idle");

        // Full rotation with done pulses, no idle gap
        do_reset();
        bus.req = 5'b11111;
        tick("rot_first");
        expect_sel("rot_0", 3'(seq[0]));
        for (int t = 1; t < 6; t++) begin
            tick("rot_hold");
            tick("rot_hold");
            bus.done = 5'(1 << m_owner);
            tick("rot_done");
            bus.done = 5'b0;
            expect_sel("rot_seq", 3'(seq[t]));
        end

        // Owner 4 drops request, wrap to 0
        do_reset();
        bus.req = 5'b10000;
        tick("own4");
        expect_sel("own4_sel", 3'd4);
        bus.req = 5'b00001;
        tick("wrap");
        expect_sel("wrap_sel", 3'd0);

        // Timeout / indefinite hold for owner 1 with requester 3 pending
        do_reset();
        bus.req = 5'b00010;
        tick("own1");
        bus.req = 5'b01010;
        pre_cnt = 0;
        if (TO_EN) begin
            for (int c = 0; c < 6; c++) begin
                tick("timeout");
                if (bus.preempt === 1'b1) pre_cnt++;
                if (c == 3) expect_sel("timeout_sel3", 3'd3);
            end
            n_checks++;
            assert (pre_cnt == 1) else begin
                n_err++; $error("FAIL preempt_pulses got %0d exp 1", pre_cnt);
            end
        end else begin
            for (int c = 0; c < 50; c++) tick("hold50");
            expect_sel("hold50_sel", 3'd1);
        end

        // Non-owner done ignored, then async reset mid-tenure
        do_reset();
        bus.req = 5'b00101;
        tick("own0");
        bus.done = 5'b00100;
        tick("done_nonowner");
        bus.done = 5'b0;
        tick("still0");
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        tick("rst_held");
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 5'($urandom_range(0, 31));
            bus.done = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
